// File: rtl/apb_master_ctrl.sv
// APB (v3) requester: one outstanding single-beat transfer, registered outputs,
// optional timeout abort when pready never arrives.
module apb_master_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADD_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADD_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADD_W-1:0]  paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADD_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    cnt_d       = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end else begin
                    // Saturate so TIMEOUT=0 (never abort) cannot wrap the counter.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_inc;
                    end
                    if ((TIMEOUT != 0) && (cnt_inc == TO_C)) begin
                        state_d     = IDLE;
                        cmd_ready_d = 1'b1;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: transaction-level model checked every cycle,
// directed scenarios with literal expectations, and a FIFO-style APB slave at 0xFF.
module tb_apb_master_ctrl;

    localparam int DATA_W  = 8;
    localparam int ADD_W   = 8;
    localparam int TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              preset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADD_W-1:0]  cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADD_W-1:0]  paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata = '0;
    logic              pready = 1'b0;

    int err_cnt = 0;
    int chk_cnt = 0;

    apb_master_ctrl #(.DATA_W(DATA_W), .ADD_W(ADD_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction model: a transfer is "busy" from the handshake until it
    // finishes; age 1 is its select-only cycle, later cycles are enable cycles.
    logic              m_busy = 1'b0;
    int                m_age = 0;
    int                m_waits = 0;
    logic              m_write = 1'b0;
    logic [ADD_W-1:0]  m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic              m_rv = 1'b0;
    logic              m_err = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            m_busy <= 1'b0; m_age <= 0; m_waits <= 0;
            m_write <= 1'b0; m_addr <= '0; m_wdata <= '0;
            m_rv <= 1'b0; m_err <= 1'b0; m_rdata <= '0;
        end else begin
            m_rv <= 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy <= 1'b1; m_age <= 1; m_waits <= 0;
                    m_write <= cmd_write; m_addr <= cmd_addr; m_wdata <= cmd_wdata;
                end
            end else if (m_age == 1) begin
                m_age <= 2;
            end else if (pready) begin
                m_busy <= 1'b0; m_rv <= 1'b1; m_err <= 1'b0;
                m_rdata <= m_write ? '0 : prdata;
            end else begin
                m_waits <= m_waits + 1;
                if (TIMEOUT != 0 && m_waits + 1 == TIMEOUT) begin
                    m_busy <= 1'b0; m_rv <= 1'b1; m_err <= 1'b1; m_rdata <= '0;
                end
            end
        end
    end

    always @(negedge pclk) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
        chk("psel",      32'(psel),      32'(m_busy));
        chk("penable",   32'(penable),   32'(m_busy && m_age >= 2));
        chk("pwrite",    32'(pwrite),    32'(m_write));
        chk("paddr",     32'(paddr),     32'(m_addr));
        chk("pwdata",    32'(pwdata),    32'(m_wdata));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_err",   32'(rsp_err),   32'(m_err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
    end

    // APB slave: address 0xFF is a FIFO port (write pushes, read pops).
    // wait_plan >= 0: that many wait cycles; -1: never ready; -2: random waits.
    int                wait_plan = 0;
    int                acc_cnt = 0;
    logic [DATA_W-1:0] fifo[$];

    initial begin
        forever begin
            logic go;
            @(posedge pclk); #1;
            prdata = 8'($urandom);
            pready = (wait_plan == -2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (psel && penable) begin
                if (wait_plan == -2) go = (acc_cnt >= 5) || ($urandom_range(0, 1) == 1);
                else                 go = (wait_plan >= 0) && (acc_cnt >= wait_plan);
                acc_cnt++;
                pready = go;
                if (go) begin
                    if (pwrite) begin
                        if (paddr == 8'hFF) fifo.push_back(pwdata);
                    end else begin
                        prdata = (paddr == 8'hFF && fifo.size() > 0) ? fifo.pop_front() : 8'h00;
                    end
                end
            end else begin
                acc_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge pclk); #1;
    endtask

    // Presents a command in an idle cycle; returns just after the handshake edge.
    task automatic do_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    // Counts cycles after the handshake up to and including the response cycle.
    task automatic wait_rsp(input int limit, output int cycles, output int pen,
                            output int psel_first, output int pen_first);
        cycles = 0; pen = 0; psel_first = 0; pen_first = 0;
        forever begin
            @(negedge pclk);
            cycles++;
            if (psel && psel_first == 0) psel_first = cycles;
            if (penable) begin
                pen++;
                if (pen_first == 0) pen_first = cycles;
            end
            if (rsp_valid) break;
            if (cycles >= limit) begin
                err_cnt++; chk_cnt++;
                $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, expected one", cycles);
                break;
            end
        end
    endtask

    initial begin
        int cyc, pen, pf, ef;
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, pen, pf, ef;
        int hs, rsps, nr, fall;
        int rises[3];
        logic was_ready, psel_prev;

        preset = 1'b1;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_psel",      32'(psel),      32'd0);
        chk("reset_paddr",     32'(paddr),     32'd0);
        chk("reset_rdata",     32'(rsp_rdata), 32'd0);
        step();

        // 1: zero-wait write
        wait_plan = 0;
        do_cmd(1'b1, 8'hFF, 8'hA5);
        wait_rsp(10, cyc, pen, pf, ef);
        chk("t1_psel_cycle",    32'(pf),  32'd1);
        chk("t1_penable_cycle", 32'(ef),  32'd2);
        chk("t1_rsp_cycle",     32'(cyc), 32'd3);
        chk("t1_err",   32'(rsp_err),   32'd0);
        chk("t1_rdata", 32'(rsp_rdata), 32'd0);
        chk("t1_psel_off", 32'(psel), 32'd0);
        step();

        // 2: read with three wait cycles
        fifo.delete();
        fifo.push_back(8'h3C);
        wait_plan = 3;
        do_cmd(1'b0, 8'hFF, 8'h00);
        wait_rsp(20, cyc, pen, pf, ef);
        chk("t2_penable_len", 32'(pen),       32'd4);
        chk("t2_rsp_cycle",   32'(cyc),       32'd6);
        chk("t2_rdata",       32'(rsp_rdata), 32'h3C);
        chk("t2_paddr",       32'(paddr),     32'hFF);
        step();

        // 3: stuck slave aborts after TIMEOUT access cycles, then a normal write
        wait_plan = -1;
        do_cmd(1'b0, 8'h10, 8'h00);
        wait_rsp(40, cyc, pen, pf, ef);
        chk("t3_penable_len", 32'(pen),       32'd16);
        chk("t3_rsp_cycle",   32'(cyc),       32'd18);
        chk("t3_err",         32'(rsp_err),   32'd1);
        chk("t3_rdata",       32'(rsp_rdata), 32'd0);
        chk("t3_psel_off",    32'(psel),      32'd0);
        step();
        wait_plan = 0;
        do_cmd(1'b1, 8'h20, 8'h5A);
        wait_rsp(10, cyc, pen, pf, ef);
        chk("t3_next_cycle", 32'(cyc),     32'd3);
        chk("t3_next_err",   32'(rsp_err), 32'd0);
        step();

        // 4: cmd_valid held for three back-to-back zero-wait writes
        hs = 0; rsps = 0; nr = 0; fall = -1; psel_prev = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'h11;
        for (int c = 0; c < 20; c++) begin
            @(negedge pclk);
            was_ready = cmd_ready;
            if (psel && !psel_prev) begin
                if (nr > 0) chk("t4_psel_low_len", 32'(c - fall), 32'd1);
                if (nr < 3) rises[nr] = c;
                nr++;
            end
            if (!psel && psel_prev) fall = c;
            if (rsp_valid) rsps++;
            psel_prev = psel;
            step();
            if (cmd_valid && was_ready) begin
                hs++;
                cmd_wdata = cmd_wdata + 8'h11;
                if (hs == 3) cmd_valid = 1'b0;
            end
            if (rsps == 3) break;
        end
        chk("t4_rsp_count",  32'(rsps), 32'd3);
        chk("t4_setup_count", 32'(nr),  32'd3);
        // SETUP, ACCESS, then the response cycle doubles as the next handshake.
        chk("t4_setup_gap1", 32'(rises[1] - rises[0]), 32'd3);
        chk("t4_setup_gap2", 32'(rises[2] - rises[1]), 32'd3);

        // 5: reset during ACCESS
        wait_plan = -1;
        do_cmd(1'b0, 8'h30, 8'h00);
        step();
        chk("t5_in_access", 32'(penable), 32'd1);
        preset = 1'b1;
        #1;
        chk("t5_psel_drop",    32'(psel),    32'd0);
        chk("t5_penable_drop", 32'(penable), 32'd0);
        step();
        preset = 1'b0;
        wait_plan = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        step();
        do_cmd(1'b1, 8'h33, 8'h77);
        wait_rsp(10, cyc, pen, pf, ef);
        chk("t5_after_cycle", 32'(cyc),     32'd3);
        chk("t5_after_err",   32'(rsp_err), 32'd0);
        step();

        // 6: FIFO slave with random wait states
        fifo.delete();
        wait_plan = -2;
        for (int i = 1; i <= 8; i++) begin
            do_cmd(1'b1, 8'hFF, 8'(i));
            wait_rsp(30, cyc, pen, pf, ef);
            chk("t6_wr_err", 32'(rsp_err), 32'd0);
            step();
        end
        for (int i = 1; i <= 8; i++) begin
            do_cmd(1'b0, 8'hFF, 8'h00);
            wait_rsp(30, cyc, pen, pf, ef);
            chk("t6_rd_err",   32'(rsp_err),   32'd0);
            chk("t6_rd_rdata", 32'(rsp_rdata), 32'(i));
            step();
        end

        repeat (2) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
